// File: rtl/fetch_bundle_queue.sv
// Fetch-to-decode bundle FIFO: 4-wide bundles, first-word-fall-through head,
// flush on misprediction, early stall to absorb the bundle already in flight.
module fetch_bundle_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_valid,
  input  logic [4*PC_WIDTH-1:0]   pc_in,
  input  logic [4*PC_WIDTH-1:0]   inst_in,
  input  logic [4*PC_WIDTH-1:0]   recv_pc_in,
  input  logic [3:0]              pred_in,
  input  logic                    flush,
  input  logic                    dec_ready,
  output logic                    dec_valid,
  output logic [4*PC_WIDTH-1:0]   pc_out,
  output logic [4*PC_WIDTH-1:0]   inst_out,
  output logic [4*PC_WIDTH-1:0]   recv_pc_out,
  output logic [3:0]              pred_out,
  output logic                    stall_fetch,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int AW      = $clog2(DEPTH);
  localparam int STALL_I = DEPTH - 1;
  localparam logic [AW:0] FULL_CNT  = DEPTH[AW:0];
  localparam logic [AW:0] STALL_CNT = STALL_I[AW:0];

  logic [4*PC_WIDTH-1:0] pc_mem   [DEPTH];
  logic [4*PC_WIDTH-1:0] inst_mem [DEPTH];
  logic [4*PC_WIDTH-1:0] recv_mem [DEPTH];
  logic [3:0]            pred_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  assign full = (count == FULL_CNT);
  assign pop  = dec_valid && dec_ready && !flush;
  // A same-cycle pop frees the slot, so a push into a full queue still lands.
  assign push = fetch_valid && !flush && (!full || pop);
  assign drop = fetch_valid && !flush && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc_in;
      inst_mem[wr_ptr] <= inst_in;
      recv_mem[wr_ptr] <= recv_pc_in;
      pred_mem[wr_ptr] <= pred_in;
    end
  end

  always_comb begin
    dec_valid   = (count != '0);
    stall_fetch = (count >= STALL_CNT);
    pc_out      = '0;
    inst_out    = '0;
    recv_pc_out = '0;
    pred_out    = '0;
    if (dec_valid) begin
      pc_out      = pc_mem[rd_ptr];
      inst_out    = inst_mem[rd_ptr];
      recv_pc_out = recv_mem[rd_ptr];
      pred_out    = pred_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Directed bench for fetch_bundle_queue with DEPTH=4, PC_WIDTH=16.
module tb_fetch_bundle_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [63:0] pc_in, inst_in, recv_pc_in;
  logic [3:0]  pred_in;
  logic        flush;
  logic        dec_ready;
  logic        dec_valid;
  logic [63:0] pc_out, inst_out, recv_pc_out;
  logic [3:0]  pred_out;
  logic        stall_fetch;
  logic [2:0]  count;
  logic        overflow;

  int unsigned errors = 0;
  int unsigned checks = 0;

  fetch_bundle_queue #(.DEPTH(4), .PC_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid),
    .pc_in(pc_in), .inst_in(inst_in), .recv_pc_in(recv_pc_in), .pred_in(pred_in),
    .flush(flush), .dec_ready(dec_ready), .dec_valid(dec_valid),
    .pc_out(pc_out), .inst_out(inst_out), .recv_pc_out(recv_pc_out), .pred_out(pred_out),
    .stall_fetch(stall_fetch), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slot i field = base + off + 4*i, slot 0 in the low word.
  function automatic logic [63:0] bundle(input logic [15:0] b, input logic [15:0] off);
    logic [15:0] s0, s1, s2, s3;
    s0 = b + off;
    s1 = b + off + 16'd4;
    s2 = b + off + 16'd8;
    s3 = b + off + 16'd12;
    return {s3, s2, s1, s0};
  endfunction

  task automatic drive(input logic [15:0] b, input logic [3:0] p);
    pc_in      = bundle(b, 16'h0000);
    inst_in    = bundle(b, 16'h1000);
    recv_pc_in = bundle(b, 16'h2000);
    pred_in    = p;
  endtask

  task automatic expect_head(input string tag, input logic [15:0] b, input logic [3:0] p);
    check({tag, ".valid"}, 64'(dec_valid), 64'd1);
    check({tag, ".pc"},    pc_out,      bundle(b, 16'h0000));
    check({tag, ".inst"},  inst_out,    bundle(b, 16'h1000));
    check({tag, ".recv"},  recv_pc_out, bundle(b, 16'h2000));
    check({tag, ".pred"},  64'(pred_out), 64'(p));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; flush = 1'b0; dec_ready = 1'b0;
    drive(16'h0, 4'h0);
    tick(); tick();
    check("rst.valid", 64'(dec_valid), 64'd0);
    check("rst.count", 64'(count), 64'd0);
    check("rst.stall", 64'(stall_fetch), 64'd0);
    check("rst.ovf",   64'(overflow), 64'd0);
    check("rst.pc",    pc_out, 64'd0);
    rst = 1'b0;
    tick();

    // single push into empty queue
    fetch_valid = 1'b1; drive(16'h0000, 4'b0010);
    tick();
    fetch_valid = 1'b0;
    expect_head("push1", 16'h0000, 4'b0010);
    check("push1.pc_lit", pc_out, 64'h000C_0008_0004_0000);
    check("push1.count", 64'(count), 64'd1);
    check("push1.stall", 64'(stall_fetch), 64'd0);

    // fill to DEPTH with decode stalled
    fetch_valid = 1'b1; drive(16'h0010, 4'h1); tick();
    check("fill2.count", 64'(count), 64'd2);
    check("fill2.stall", 64'(stall_fetch), 64'd0);
    drive(16'h0020, 4'h2); tick();
    check("fill3.count", 64'(count), 64'd3);
    check("fill3.stall", 64'(stall_fetch), 64'd1);
    drive(16'h0030, 4'h3); tick();
    check("fill4.count", 64'(count), 64'd4);
    check("fill4.ovf",   64'(overflow), 64'd0);

    // full with simultaneous push and pop
    dec_ready = 1'b1; drive(16'h0040, 4'h4); tick();
    check("pp.count", 64'(count), 64'd4);
    check("pp.ovf",   64'(overflow), 64'd0);
    expect_head("pp.head", 16'h0010, 4'h1);

    // push while full without pop is dropped
    dec_ready = 1'b0; drive(16'h0050, 4'h5); tick();
    fetch_valid = 1'b0;
    check("drop.count", 64'(count), 64'd4);
    check("drop.ovf",   64'(overflow), 64'd1);
    expect_head("drop.head", 16'h0010, 4'h1);

    // drain: dropped bundle must not appear
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_head($sformatf("drain%0d", i), 16'(16'h0010 + 16'h0010 * i), 4'(i + 1));
      tick();
    end
    dec_ready = 1'b0;
    check("drained.valid", 64'(dec_valid), 64'd0);
    check("drained.count", 64'(count), 64'd0);
    check("drained.pc",    pc_out, 64'd0);
    check("drained.ovf",   64'(overflow), 64'd1);

    // stream 10 bundles with decode always ready; pointers wrap
    dec_ready = 1'b1; fetch_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(16'(4 * k), 4'(k));
      tick();
      expect_head($sformatf("stream%0d", k), 16'(4 * k), 4'(k));
      check($sformatf("stream%0d.count", k), 64'(count), 64'd1);
    end
    fetch_valid = 1'b0; tick();
    check("stream.end", 64'(count), 64'd0);

    // flush with count 3 while push and pop are also presented
    dec_ready = 1'b0; fetch_valid = 1'b1;
    drive(16'h0100, 4'h1); tick();
    drive(16'h0110, 4'h2); tick();
    drive(16'h0120, 4'h3); tick();
    check("preflush.count", 64'(count), 64'd3);
    check("preflush.stall", 64'(stall_fetch), 64'd1);
    drive(16'h0130, 4'h4); dec_ready = 1'b1; flush = 1'b1; tick();
    flush = 1'b0; dec_ready = 1'b0;
    check("flush.count", 64'(count), 64'd0);
    check("flush.valid", 64'(dec_valid), 64'd0);
    check("flush.stall", 64'(stall_fetch), 64'd0);
    check("flush.pc",    pc_out, 64'd0);
    drive(16'h0200, 4'h9); tick();
    expect_head("postflush", 16'h0200, 4'h9);
    check("postflush.count", 64'(count), 64'd1);

    // async reset between edges with count 2
    drive(16'h0210, 4'hA); tick();
    fetch_valid = 1'b0;
    check("prerst.count", 64'(count), 64'd2);
    check("prerst.ovf",   64'(overflow), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst.valid", 64'(dec_valid), 64'd0);
    check("arst.count", 64'(count), 64'd0);
    check("arst.stall", 64'(stall_fetch), 64'd0);
    check("arst.ovf",   64'(overflow), 64'd0);
    check("arst.pc",    pc_out, 64'd0);
    check("arst.pred",  64'(pred_out), 64'd0);
    #1 rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
